// File: rtl/align_captures_core_pkg.sv
// Shared defaults and FSM state encoding for the capture aligner.
// CLEAR/VALID sit just after/before the middle of the sample period.
package align_captures_core_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int RATIO_DEF = 12;
  localparam int RBITS_DEF = 4;
  localparam int HALF_DEF  = RATIO_DEF / 2;
  localparam int CLEAR_DEF = HALF_DEF + 1;
  localparam int VALID_DEF = HALF_DEF - 1;

  typedef enum logic {
    SEEK = 1'b0,
    SYNC = 1'b1
  } state_t;

endpackage

// File: rtl/align_captures_core_if.sv
// Capture-side bus into the aligner plus the aligned-word outputs.
// The miss counter output exists only when ALIGN_MISS_COUNT_EN is defined.
interface align_captures_core_if
  import align_captures_core_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             enable_i;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] strobes;
  logic [WIDTH-1:0] lockeds;
  logic [WIDTH-1:0] invalids;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic             locked;
  logic             invalid;
`ifdef ALIGN_MISS_COUNT_EN
  logic [7:0]       misses_o;

  modport master (
    output enable_i, data_in, strobes, lockeds, invalids, ack,
    input  data_out, ready, locked, invalid, misses_o
  );
  modport slave (
    input  enable_i, data_in, strobes, lockeds, invalids, ack,
    output data_out, ready, locked, invalid, misses_o
  );
`else
  modport master (
    output enable_i, data_in, strobes, lockeds, invalids, ack,
    input  data_out, ready, locked, invalid
  );
  modport slave (
    input  enable_i, data_in, strobes, lockeds, invalids, ack,
    output data_out, ready, locked, invalid
  );
`endif
endinterface

// File: rtl/align_captures_core_phase_counter.sv
// Modulo-RATIO phase counter: load jumps to phase 1, run advances, otherwise parks at 0.
// Latency: new phase one cycle after load/run; no backpressure (free-running).
module align_phase_counter
  import align_captures_core_pkg::*;
#(
  parameter int RATIO = RATIO_DEF,
  parameter int RBITS = RBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  output logic [RBITS-1:0] phase
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (load) begin
      phase <= RBITS'(1);
    end else if (!run) begin
      phase <= '0;
    end else if (phase == RBITS'(RATIO - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + RBITS'(1);
    end
  end

endmodule

// File: rtl/align_captures_core.sv
// Realigns per-bit strobed captures into one word per RATIO cycles; ready one cycle after phase VALID.
// No backpressure. Define ALIGN_MISS_COUNT_EN to add the saturating misses_o counter.
module align_captures_core
  import align_captures_core_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RATIO = RATIO_DEF,
  parameter int RBITS = RBITS_DEF,
  parameter int CLEAR = CLEAR_DEF,
  parameter int VALID = VALID_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  align_captures_core_if.slave  io
);

  state_t           state, state_nxt;
  logic [RBITS-1:0] phase;
  logic [WIDTH-1:0] flag;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] dup;
  logic             all_locked, any_strobe;
  logic             sync_hit, active, capture;
  logic             at_valid, at_clear, word_ok, missing, err;

  assign all_locked = &io.lockeds;
  assign any_strobe = |io.strobes;
  assign sync_hit   = io.enable_i && (state == SEEK) && all_locked && any_strobe;
  assign active     = io.enable_i && (state == SYNC) && all_locked;
  assign capture    = sync_hit || active;
  assign at_valid   = active && (phase == RBITS'(VALID));
  assign at_clear   = active && (phase == RBITS'(CLEAR));
  assign word_ok    = at_valid && (&flag);
  assign missing    = at_valid && !(&flag);
  // A strobe landing on the clear phase starts a fresh window, so it is never a duplicate.
  assign dup        = (capture && !at_clear) ? (io.strobes & flag) : '0;
  assign err        = (|dup) || missing || (active && (|io.invalids));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEEK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!io.enable_i) begin
      state_nxt = SEEK;
    end else begin
      case (state)
        SEEK:    if (all_locked && any_strobe) state_nxt = SYNC;
        SYNC:    if (!all_locked) state_nxt = SEEK;
        default: state_nxt = SEEK;
      endcase
    end
  end

  always_comb begin
    io.locked = (state == SYNC);
  end

  align_phase_counter #(
    .RATIO (RATIO),
    .RBITS (RBITS)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sync_hit),
    .run   (active),
    .phase (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= '0;
      hold <= '0;
    end else if (!capture) begin
      flag <= '0;
    end else begin
      hold <= (hold & ~io.strobes) | (io.data_in & io.strobes);
      flag <= (at_clear ? '0 : flag) | io.strobes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.data_out <= '0;
      io.ready    <= 1'b0;
      io.invalid  <= 1'b0;
    end else begin
      io.ready <= word_ok;
      if (word_ok) io.data_out <= hold;
      if (err)         io.invalid <= 1'b1;
      else if (io.ack) io.invalid <= 1'b0;
    end
  end

`ifdef ALIGN_MISS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.misses_o <= '0;
    end else if (io.ack) begin
      io.misses_o <= '0;
    end else if (missing && (io.misses_o != 8'hFF)) begin
      io.misses_o <= io.misses_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_align_captures_core.sv
// Bench for align_captures_core: period-based stimulus against a strobe-counting reference model.
module tb_align_captures_core;
  import align_captures_core_pkg::*;

  localparam int W   = 8;
  localparam int R   = 12;
  localparam int VAL = VALID_DEF;
  localparam int CLR = CLEAR_DEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  align_captures_core_if #(.WIDTH(W)) bus ();

  align_captures_core #(
    .WIDTH (W),
    .RATIO (R),
    .RBITS (4),
    .CLEAR (CLR),
    .VALID (VAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_seen = 0;
  int last_rdy_cyc = -1;
  int per_start    = 0;

  // Reference model: absolute cycle of the sync strobe, strobe counts per window.
  bit           m_sync;
  int           m_c0;
  int           m_cnt [W];
  logic [W-1:0] m_hold;
  logic [W-1:0] m_dout;
  bit           m_rdy;
  bit           m_inv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_sync = 0;
    m_c0   = 0;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
    m_hold = '0;
    m_dout = '0;
    m_rdy  = 0;
    m_inv  = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] stb;
    bit err;
    bit fire;
    bit all_seen;
    int ph;
    stb  = bus.strobes;
    err  = 0;
    fire = 0;
    if (!bus.enable_i) begin
      m_sync = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
    end else if (!m_sync) begin
      if ((&bus.lockeds) && (|stb)) begin
        m_sync = 1;
        m_c0   = cyc;
        for (int i = 0; i < W; i++)
          if (stb[i]) begin
            m_cnt[i]  = 1;
            m_hold[i] = bus.data_in[i];
          end
      end
    end else if (!(&bus.lockeds)) begin
      m_sync = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
    end else begin
      ph = (cyc - m_c0) % R;
      if (|bus.invalids) err = 1;
      if (ph == VAL) begin
        all_seen = 1;
        for (int i = 0; i < W; i++) if (m_cnt[i] == 0) all_seen = 0;
        if (all_seen) begin
          fire   = 1;
          m_dout = m_hold;
        end else begin
          err = 1;
        end
      end
      for (int i = 0; i < W; i++) begin
        if (ph == CLR) m_cnt[i] = 0;
        if (stb[i]) begin
          if (m_cnt[i] > 0) err = 1;
          m_cnt[i]++;
          m_hold[i] = bus.data_in[i];
        end
      end
    end
    m_rdy = fire;
    if (err)          m_inv = 1;
    else if (bus.ack) m_inv = 0;
  endtask

  // One clock: compare at negedge, advance the model with this cycle's inputs.
  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      check("ready",    bus.ready,    m_rdy);
      check("data_out", bus.data_out, m_dout);
      check("locked",   bus.locked,   m_sync);
      check("invalid",  bus.invalid,  m_inv);
      if (bus.ready === 1'b1) begin
        rdy_seen++;
        last_rdy_cyc = cyc;
      end
      model_step();
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_period(input logic [W-1:0] sample, input bit jit, input int miss_bit,
                            input bit dup0, input int ack_ph, input int drop_ph);
    int sph [W];
    logic [W-1:0] s;
    per_start = cyc;
    for (int i = 0; i < W; i++)
      sph[i] = (i == 0) ? 0 : 1 + 2 * (i % 2) + (jit ? int'($urandom_range(2)) - 1 : 0);
    bus.data_in = sample;
    for (int p = 0; p < R; p++) begin
      s = '0;
      for (int i = 0; i < W; i++) if (sph[i] == p && i != miss_bit) s[i] = 1'b1;
      if (dup0 && p == 2) s[0] = 1'b1;
      bus.strobes = s;
      bus.ack     = (p == ack_ph);
      bus.lockeds = (drop_ph >= 0 && p >= drop_ph) ? 8'hDF : 8'hFF;
      step();
    end
    bus.strobes = '0;
    bus.ack     = 1'b0;
    bus.lockeds = 8'hFF;
  endtask

  initial begin
    int r0;
    logic [W-1:0] smp;
    bus.enable_i = 1'b1;
    bus.data_in  = '0;
    bus.strobes  = '0;
    bus.lockeds  = 8'hFF;
    bus.invalids = '0;
    bus.ack      = 1'b0;
    model_reset();

    repeat (3) step();
    check("rst_ready",   bus.ready,    0);
    check("rst_locked",  bus.locked,   0);
    check("rst_invalid", bus.invalid,  0);
    check("rst_dout",    bus.data_out, 0);
    rst_n = 1'b1;
    repeat (4) step();

    // Aligned stream
    r0 = rdy_seen;
    run_period(8'hA5, 0, -1, 0, -1, -1);
    check("first_ready_phase", last_rdy_cyc - per_start, VAL + 1);
    for (int k = 0; k < 5; k++) run_period(8'hA5, 0, -1, 0, -1, -1);
    check("aligned_ready_phase", last_rdy_cyc - per_start, VAL + 1);
    check("aligned_ready_count", rdy_seen - r0, 6);
    check("aligned_dout", bus.data_out, 8'hA5);
    check("aligned_inv",  bus.invalid, 0);

    // Missing bit 3
    r0 = rdy_seen;
    run_period(8'h3C, 0, 3, 0, -1, -1);
    check("miss_no_ready", rdy_seen - r0, 0);
    check("miss_inv",      bus.invalid, 1);
    check("miss_dout_hold", bus.data_out, 8'hA5);
    run_period(8'h3C, 0, -1, 0, 2, -1);
    check("miss_ack_clears", bus.invalid, 0);
    check("miss_next_word",  bus.data_out, 8'h3C);

    // Duplicate strobe on bit 0, then ack colliding with a new duplicate
    run_period(8'h5A, 0, -1, 1, -1, -1);
    check("dup_inv",  bus.invalid, 1);
    check("dup_word", bus.data_out, 8'h5A);
    run_period(8'h5A, 0, -1, 1, 2, -1);
    check("dup_ack_collide", bus.invalid, 1);
    run_period(8'h5A, 0, -1, 0, 0, -1);
    check("dup_cleared", bus.invalid, 0);

    // Lock loss on lockeds[5] mid-period, then re-sync
    r0 = rdy_seen;
    run_period(8'h81, 0, -1, 0, -1, 2);
    check("lost_locked",   bus.locked, 0);
    check("lost_no_ready", rdy_seen - r0, 0);
    run_period(8'h81, 0, -1, 0, -1, -1);
    check("resync_locked", bus.locked, 1);
    check("resync_ready",  rdy_seen - r0, 1);
    check("resync_word",   bus.data_out, 8'h81);

    // Random data with stagger and jitter
    r0 = rdy_seen;
    for (int k = 0; k < 34; k++) begin
      smp = W'($urandom);
      run_period(smp, 1, -1, 0, -1, -1);
      check("rand_word", bus.data_out, smp);
    end
    check("rand_ready_count", rdy_seen - r0, 34);
    check("rand_inv", bus.invalid, 0);

    // Reset mid-stream
    run_period(8'hA5, 1, -1, 0, -1, -1);
    rst_n = 1'b0;
    #1;
    check("midrst_dout",   bus.data_out, 0);
    check("midrst_ready",  bus.ready,    0);
    check("midrst_locked", bus.locked,   0);
    check("midrst_inv",    bus.invalid,  0);
    repeat (9) step();
    rst_n = 1'b1;
    repeat (6) step();
    check("post_rst_locked", bus.locked, 0);
    check("post_rst_ready",  bus.ready,  0);
    r0 = rdy_seen;
    run_period(8'h96, 1, -1, 0, -1, -1);
    run_period(8'h69, 1, -1, 0, -1, -1);
    check("post_rst_readies", rdy_seen - r0, 2);
    check("post_rst_word",    bus.data_out, 8'h69);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
